// File: rtl/mantissa_mul_seq.sv
// Sequential unsigned/two's-complement multiplier that retires K multiplier bits per cycle
// on sign-stripped magnitudes and applies the result sign once at the end.
module mantissa_mul_seq #(
  parameter int N = 24,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           signed_mode,
  input  logic [N-1:0]   M,
  input  logic [N-1:0]   Q,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] R,
  output logic           busy
);

  localparam int STEPS = N / K;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q;
  logic [N-1:0]   mag_m_q;
  logic [N-1:0]   mag_q_q;
  logic           sign_q;
  logic [2*N-1:0] acc_q;
  logic [2*N-1:0] r_q;
  logic [CW-1:0]  cnt_q;
  logic           out_valid_q;

  logic [N-1:0]   q_shift;
  logic [K-1:0]   digit;
  logic [N+K-1:0] pp;
  logic [2*N-1:0] pp_ext;
  logic [2*N-1:0] acc_d;
  logic [2*N-1:0] r_d;

  // Two's-complement negate when requested; -2^(N-1) maps onto 2^(N-1) as unsigned.
  function automatic logic [N-1:0] magnitude(input logic [N-1:0] v, input logic neg);
    return neg ? (~v + {{(N-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [2*N-1:0] apply_sign(input logic [2*N-1:0] v, input logic neg);
    return neg ? (~v + {{(2*N-1){1'b0}}, 1'b1}) : v;
  endfunction

  always_comb begin
    q_shift = mag_q_q >> (int'(cnt_q) * K);
    digit   = q_shift[K-1:0];
    pp      = {{K{1'b0}}, mag_m_q} * {{N{1'b0}}, digit};
    pp_ext  = '0;
    pp_ext[N+K-1:0] = pp;
    acc_d   = acc_q + (pp_ext << (int'(cnt_q) * K));
    r_d     = apply_sign(acc_d, sign_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mag_m_q     <= '0;
      mag_q_q     <= '0;
      sign_q      <= 1'b0;
      acc_q       <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mag_m_q <= magnitude(M, signed_mode & M[N-1]);
            mag_q_q <= magnitude(Q, signed_mode & Q[N-1]);
            // A zero operand never produces a negative zero.
            sign_q  <= signed_mode & (M[N-1] ^ Q[N-1]) & (|M) & (|Q);
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          if (cnt_q == LAST) begin
            r_q         <= r_d;
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign R         = r_q;

endmodule
